video_stream_sync_ctrl: RTL and testbench
=========================================

Name: video_stream_sync_ctrl

Overview:
- Sequences DVI output start-up and recovery against the camera pixel stream.
- Holds the VGA timing core in reset until a camera frame has started and the pixel FIFO holds enough data.
- Then gates FIFO reads with display-enable, detects underflow, and forces a flush/resync after repeated bad frames.
- Sits between the camera-side pixel FIFO and the video output chain (colour balance, TMDS encode); all logic is in the pixel clock domain.

Parameters:
- FIFO_AW, 11, FIFO address width; fifo_level is FIFO_AW+1 bits.
- PREFILL_LVL, 640, minimum FIFO level before timing is released (one 640-pixel line).
- UF_MAX, 3, consecutive underflowing frames that trigger a resync; range 1..15.
- VS_POL, 0, vsync active level (0 = negative polarity).

Ports:
- clk_pix  in  1  pixel clock; only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- cam_sof  in  1  one-cycle pulse: first pixel of a camera frame written to FIFO.
- fifo_level  in  FIFO_AW+1  current FIFO fill.
- fifo_empty  in  1  FIFO empty flag.
- de_i  in  1  display enable from the timing core.
- vsync_i  in  1  vsync from the timing core.
- timing_rst  out  1  reset to the timing core.
- pixel_request  out  1  FIFO read enable.
- blank_o  out  1  forces black pixels; aligned to FIFO read data.
- fifo_flush  out  1  one-cycle FIFO flush pulse.
- underflow_o  out  1  one-cycle pulse per underflowing pixel.
- state_o  out  3  current state encoding.
- frame_cnt  out  16  displayed frames counter.

Behaviour:
- Clock and reset: single clock clk_pix; reset rst is synchronous, active-high.
- Reset values:
  - state IDLE; timing_rst=1; pixel_request=0; blank_o=1.
  - fifo_flush=0; underflow_o=0; frame_cnt=0.
  - uf_frames=0; frame_uf=0; vs_act_d=0.
- State encoding: IDLE=0, WAIT_SOF=1, PREFILL=2, RUN=3, RESYNC=4.
- Priority: rst > enable low > state transitions.
  - enable=0 in any state -> IDLE on the next edge. No flush is issued.
- IDLE: timing_rst=1. If enable=1 -> WAIT_SOF.
- WAIT_SOF: timing_rst=1. cam_sof=1 -> PREFILL.
- PREFILL:
  - timing_rst=1; cam_sof is ignored.
  - fifo_level >= PREFILL_LVL -> RUN, with uf_frames and frame_uf cleared.
- timing_rst is registered and equals (next_state != RUN). It is therefore 0 in the first RUN cycle.
- RUN read path:
  - pixel_request is combinational: (state==RUN) & de_i & ~fifo_empty.
  - blank_o is registered: blank_o <= ~pixel_request. This gives 1-cycle alignment with the FIFO's 1-cycle read latency.
- RUN underflow:
  - de_i=1 & fifo_empty=1 -> underflow_o=1 on the next cycle (registered), and frame_uf set.
- Frame boundary:
  - vs_act = (vsync_i == VS_POL); vs_act_d is its registered copy.
  - A frame boundary is the cycle where vs_act=1 & vs_act_d=0, evaluated in RUN only.
  - At the boundary, frame_cnt increments, wrapping 0xFFFF -> 0.
  - If frame_uf, or an underflow in the same cycle: uf_frames += 1 (saturating at 15). Otherwise uf_frames = 0.
  - frame_uf is cleared at the boundary.
  - If the updated uf_frames >= UF_MAX -> RESYNC.
- RESYNC:
  - Lasts exactly one cycle: fifo_flush=1, timing_rst=1, pixel_request=0.
  - Then -> WAIT_SOF. uf_frames and frame_uf are cleared.
- Outside RUN: pixel_request=0; blank_o goes to 1 one cycle after leaving RUN; underflow_o=0.
- frame_cnt holds its value outside RUN and is cleared only by rst.
- Reset mid-frame: all outputs return to reset values on the first edge with rst=1. The FIFO is not flushed by this block.
- Underflow while de_i=0 is not counted (fifo_empty during blanking is legal).

Test Plan:
- Reset: rst=1 for 3 cycles with enable=1 -> state_o=0, timing_rst=1, blank_o=1, frame_cnt=0. After release -> state_o=1 on the next edge.
- Start-up: cam_sof pulse; fifo_level ramps 0 -> 639 -> 640 -> state_o=3 on the edge after level reaches 640, timing_rst=0 in that same cycle. level=639 keeps state_o=2.
- Read gating: in RUN, de_i=1 for 640 cycles, FIFO never empty -> exactly 640 pixel_request cycles, and blank_o=0 from 1 cycle after de_i rises to 1 cycle after de_i falls.
- Underflow recovery (UF_MAX=3):
  - fifo_empty forced during de_i in 3 consecutive frames -> underflow_o pulses each time.
  - After the 3rd vsync boundary: state_o=4 for 1 cycle, fifo_flush=1, then state_o=1.
  - A clean frame in between resets the count, so no resync occurs.
- Frame count wrap: preload via 65536 boundaries (or force) -> frame_cnt 0xFFFF -> 0x0000. VS_POL=1 variant counts on the vsync rising edge.
- Enable drop: enable=0 mid-RUN with de_i=1 -> next edge state_o=0, pixel_request=0, timing_rst=1, no fifo_flush. Re-enable -> WAIT_SOF.

Source files
------------

// File: rtl/video_stream_sync_ctrl.sv
// rtl/video_stream_sync_ctrl.sv - DVI output start-up, read gating and underflow resync sequencer
module video_stream_sync_ctrl #(
  parameter int FIFO_AW     = 11,
  parameter int PREFILL_LVL = 640,
  parameter int UF_MAX      = 3,
  parameter bit VS_POL      = 1'b0
) (
  input  logic               clk_pix,
  input  logic               rst,
  input  logic               enable,
  input  logic               cam_sof,
  input  logic [FIFO_AW:0]   fifo_level,
  input  logic               fifo_empty,
  input  logic               de_i,
  input  logic               vsync_i,
  output logic               timing_rst,
  output logic               pixel_request,
  output logic               blank_o,
  output logic               fifo_flush,
  output logic               underflow_o,
  output logic [2:0]         state_o,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_PREFILL  = 3'd2,
    ST_RUN      = 3'd3,
    ST_RESYNC   = 3'd4
  } state_t;

  localparam logic [FIFO_AW:0] PREFILL_L = PREFILL_LVL[FIFO_AW:0];
  localparam logic [3:0]       UF_MAX_L  = UF_MAX[3:0];

  state_t     state_q;
  state_t     state_d;
  logic [3:0] uf_frames;
  logic [3:0] uf_frames_upd;
  logic       frame_uf;
  logic       vs_act;
  logic       vs_act_d;
  logic       running;
  logic       uf_now;
  logic       boundary;
  logic       uf_clear;

  assign vs_act   = (vsync_i == VS_POL);
  assign running  = (state_q == ST_RUN);
  assign uf_now   = running & de_i & fifo_empty;
  assign boundary = running & vs_act & ~vs_act_d;

  // An underflow in the boundary cycle itself still marks the closing frame as bad.
  always_comb begin
    uf_frames_upd = 4'd0;
    if (frame_uf || uf_now) begin
      uf_frames_upd = (uf_frames == 4'hF) ? 4'hF : uf_frames + 4'd1;
    end
  end

  assign uf_clear = (state_q == ST_RESYNC) ||
                    ((state_q == ST_PREFILL) && (state_d == ST_RUN));

  // State register
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (cam_sof) state_d = ST_PREFILL;
        ST_PREFILL:  if (fifo_level >= PREFILL_L) state_d = ST_RUN;
        ST_RUN:      if (boundary && (uf_frames_upd >= UF_MAX_L)) state_d = ST_RESYNC;
        ST_RESYNC:   state_d = ST_WAIT_SOF;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pixel_request = running & de_i & ~fifo_empty;
    fifo_flush    = (state_q == ST_RESYNC);
    state_o       = state_q;
  end

  // timing_rst looks ahead at state_d so the timing core leaves reset in the first RUN cycle.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      timing_rst  <= 1'b1;
      blank_o     <= 1'b1;
      underflow_o <= 1'b0;
      vs_act_d    <= 1'b0;
      frame_cnt   <= 16'd0;
      uf_frames   <= 4'd0;
      frame_uf    <= 1'b0;
    end else begin
      timing_rst  <= (state_d != ST_RUN);
      blank_o     <= ~pixel_request;
      underflow_o <= uf_now;
      vs_act_d    <= vs_act;
      if (boundary) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (uf_clear) begin
        uf_frames <= 4'd0;
        frame_uf  <= 1'b0;
      end else if (boundary) begin
        uf_frames <= uf_frames_upd;
        frame_uf  <= 1'b0;
      end else if (uf_now) begin
        frame_uf  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_sync_ctrl.sv
// tb/tb_video_stream_sync_ctrl.sv - self-checking bench for video_stream_sync_ctrl
module tb_video_stream_sync_ctrl;

  localparam int AW = 11;

  logic          clk_pix = 1'b0;
  logic          rst;
  logic          enable;
  logic          cam_sof;
  logic [AW:0]   fifo_level;
  logic          fifo_empty;
  logic          de_i;
  logic          vsync_i;

  logic [1:0]    trst_w;
  logic [1:0]    preq_w;
  logic [1:0]    blank_w;
  logic [1:0]    flush_w;
  logic [1:0]    uf_w;
  logic [2:0]    st_w [2];
  logic [15:0]   fcnt_w [2];

  always #5 clk_pix = ~clk_pix;

  video_stream_sync_ctrl #(.FIFO_AW(AW), .PREFILL_LVL(640), .UF_MAX(3), .VS_POL(1'b0)) dut0 (
    .clk_pix(clk_pix), .rst(rst), .enable(enable), .cam_sof(cam_sof),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .de_i(de_i), .vsync_i(vsync_i),
    .timing_rst(trst_w[0]), .pixel_request(preq_w[0]), .blank_o(blank_w[0]),
    .fifo_flush(flush_w[0]), .underflow_o(uf_w[0]), .state_o(st_w[0]), .frame_cnt(fcnt_w[0])
  );

  video_stream_sync_ctrl #(.FIFO_AW(AW), .PREFILL_LVL(640), .UF_MAX(3), .VS_POL(1'b1)) dut1 (
    .clk_pix(clk_pix), .rst(rst), .enable(enable), .cam_sof(cam_sof),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .de_i(de_i), .vsync_i(vsync_i),
    .timing_rst(trst_w[1]), .pixel_request(preq_w[1]), .blank_o(blank_w[1]),
    .fifo_flush(flush_w[1]), .underflow_o(uf_w[1]), .state_o(st_w[1]), .frame_cnt(fcnt_w[1])
  );

  typedef struct {
    int st;
    bit trst;
    bit blank;
    bit uf;
    int frames;
    int ufc;
    bit fuf;
    bit vsd;
  } mdl_t;

  mdl_t m [2];
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   uf_cnt = 0;
  bit   saw_resync = 1'b0;
  bit   saw_flush = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.trst = 1'b1; r.blank = 1'b1; r.uf = 1'b0;
    r.frames = 0; r.ufc = 0; r.fuf = 1'b0; r.vsd = 1'b0;
    return r;
  endfunction

  function automatic bit exp_req(input mdl_t c);
    return (c.st == 3) && de_i && !fifo_empty;
  endfunction

  // Reference: one pixel-clock step of the sequencer described in plain terms.
  function automatic mdl_t step(input mdl_t c, input int pol);
    mdl_t n;
    bit   running, bad, req, vs, edge_seen;
    int   nst;
    if (rst) return mreset();
    n         = c;
    running   = (c.st == 3);
    req       = running && de_i && !fifo_empty;
    bad       = running && de_i && fifo_empty;
    vs        = (int'(vsync_i) == pol);
    edge_seen = running && vs && !c.vsd;
    n.vsd     = vs;
    n.blank   = !req;
    n.uf      = bad;
    if (edge_seen) begin
      n.frames = (c.frames + 1) % 65536;
      n.ufc    = (c.fuf || bad) ? ((c.ufc < 15) ? c.ufc + 1 : 15) : 0;
      n.fuf    = 1'b0;
    end else if (bad) begin
      n.fuf = 1'b1;
    end
    nst = c.st;
    if (!enable) nst = 0;
    else begin
      case (c.st)
        0: nst = 1;
        1: if (cam_sof) nst = 2;
        2: if (int'(fifo_level) >= 640) nst = 3;
        3: if (edge_seen && n.ufc >= 3) nst = 4;
        4: nst = 1;
        default: nst = 0;
      endcase
    end
    if (c.st == 4 || (c.st == 2 && nst == 3)) begin
      n.ufc = 0;
      n.fuf = 1'b0;
    end
    n.st   = nst;
    n.trst = (nst != 3);
    return n;
  endfunction

  task automatic tick();
    mdl_t n [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pixel_request%0d", k), preq_w[k], exp_req(m[k]));
      n[k] = step(m[k], k);
    end
    if (preq_w[0] === 1'b1) req_cnt++;
    @(posedge clk_pix);
    m = n;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), st_w[k], m[k].st);
      chk($sformatf("timing_rst%0d", k), trst_w[k], m[k].trst);
      chk($sformatf("blank%0d", k), blank_w[k], m[k].blank);
      chk($sformatf("underflow%0d", k), uf_w[k], m[k].uf);
      chk($sformatf("fifo_flush%0d", k), flush_w[k], m[k].st == 4);
      chk($sformatf("frame_cnt%0d", k), fcnt_w[k], m[k].frames);
    end
    if (uf_w[0] === 1'b1) uf_cnt++;
    if (st_w[0] === 3'd4) saw_resync = 1'b1;
    if (flush_w[0] === 1'b1) saw_flush = 1'b1;
  endtask

  task automatic ticks(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  // One display frame: active line with 'bad' empty pixels, blanking, then a vsync pulse (low).
  task automatic frame(input int bad);
    vsync_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      de_i       = 1'b1;
      fifo_empty = (i >= 10) && (i < 10 + bad);
      tick();
    end
    de_i = 1'b0; fifo_empty = 1'b0;
    ticks(5);
    vsync_i = 1'b0;
    ticks(3);
    vsync_i = 1'b1;
    ticks(3);
  endtask

  task automatic start_run();
    cam_sof = 1'b1; fifo_level = '0;
    tick();
    cam_sof = 1'b0; fifo_level = 12'd640;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; cam_sof = 1'b0; fifo_level = '0;
    fifo_empty = 1'b0; de_i = 1'b0; vsync_i = 1'b1;
    @(posedge clk_pix);
    m[0] = mreset(); m[1] = mreset();
    ticks(2);
    chk("reset_state", st_w[0], 0);
    chk("reset_timing_rst", trst_w[0], 1);
    chk("reset_blank", blank_w[0], 1);
    chk("reset_frame_cnt", fcnt_w[0], 0);

    rst = 1'b0;
    tick();
    chk("release_wait_sof", st_w[0], 1);

    cam_sof = 1'b1;
    tick();
    cam_sof = 1'b0;
    tick();
    fifo_level = 12'd639;
    tick();
    chk("prefill_639_holds", st_w[0], 2);
    fifo_level = 12'd640;
    tick();
    chk("run_at_640", st_w[0], 3);
    chk("run_timing_rst_low", trst_w[0], 0);

    req_cnt = 0;
    de_i = 1'b1; fifo_empty = 1'b0;
    tick();
    chk("blank_low_after_de", blank_w[0], 0);
    ticks(639);
    de_i = 1'b0;
    tick();
    chk("blank_high_after_de", blank_w[0], 1);
    ticks(3);
    chk("line_request_count", req_cnt, 640);

    uf_cnt = 0; saw_resync = 1'b0; saw_flush = 1'b0;
    frame(2); frame(2); frame(2);
    chk("uf_pulse_count", uf_cnt, 6);
    chk("resync_seen", saw_resync, 1);
    chk("flush_seen", saw_flush, 1);
    chk("after_resync_wait_sof", st_w[0], 1);

    start_run();
    chk("rerun", st_w[0], 3);
    saw_resync = 1'b0;
    frame(1); frame(1); frame(0); frame(1); frame(1);
    chk("clean_frame_no_resync", saw_resync, 0);
    chk("clean_frame_still_run", st_w[0], 3);

    de_i = 1'b1;
    tick();
    saw_flush = 1'b0;
    enable = 1'b0;
    tick();
    chk("drop_idle", st_w[0], 0);
    chk("drop_timing_rst", trst_w[0], 1);
    chk("drop_pixel_request", preq_w[0], 0);
    chk("drop_no_flush", saw_flush, 0);
    de_i = 1'b0;
    enable = 1'b1;
    tick();
    chk("reenable_wait_sof", st_w[0], 1);

    start_run();
    force dut0.frame_cnt = 16'hFFFE;
    #1;
    release dut0.frame_cnt;
    m[0].frames = 16'hFFFE;
    frame(0);
    chk("wrap_ffff", fcnt_w[0], 16'hFFFF);
    frame(0);
    chk("wrap_zero", fcnt_w[0], 0);

    for (int i = 0; i < 3000; i++) begin
      de_i       = (i % 50) < 40;
      vsync_i    = !((i % 400) < 4);
      fifo_empty = ($urandom % 8) == 0;
      cam_sof    = ($urandom % 30) == 0;
      fifo_level = 12'($urandom_range(600, 700));
      enable     = ($urandom % 300) != 0;
      rst        = ($urandom % 1500) == 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
